// File: rtl/rvv_pkg.sv
// Shared definitions for the vector ALU sequencer: function codes, element
// width codes, sequencer states and the per-element chunk count helper.
package rvv_pkg;

  localparam logic [5:0] OP_VADD  = 6'b000000;
  localparam logic [5:0] OP_VSUB  = 6'b000010;
  localparam logic [5:0] OP_VAND  = 6'b001001;
  localparam logic [5:0] OP_VOR   = 6'b001010;
  localparam logic [5:0] OP_VXOR  = 6'b001011;
  localparam logic [5:0] OP_VMAND = 6'b011001;
  localparam logic [5:0] OP_VMOR  = 6'b011010;
  localparam logic [5:0] OP_VMXOR = 6'b011011;

  localparam logic [2:0] SEW8  = 3'd0;
  localparam logic [2:0] SEW16 = 3'd1;
  localparam logic [2:0] SEW32 = 3'd2;
  localparam logic [2:0] SEW64 = 3'd3;

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} seq_state_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic       instr_mask;
    logic [2:0] vsew;
    logic [7:0] vl;
  } op_cfg_t;

  // Lane-sized chunks per element: SEW/LW when the element is wider than a lane.
  function automatic logic [7:0] chunks_for(input logic [2:0] vsew, input int lane_width);
    int lg;
    lg = int'(vsew) + 3;
    if (lg > lane_width) return 8'(1 << (lg - lane_width));
    return 8'd1;
  endfunction

endpackage

// File: rtl/rvv_alu_seq_if.sv
// Sequencer <-> ALU handshake: walk counters and function code out, lane result back.
interface rvv_alu_seq_if;
  logic        alu_run;
  logic [9:0]  alu_byte_i;
  logic [3:0]  alu_in_reg_offset;
  logic [5:0]  alu_opcode;
  logic        alu_instr_mask;
  logic        alu_valid;
  logic [63:0] alu_vd;
  logic [9:0]  alu_index;

  modport master (
    output alu_run, alu_byte_i, alu_in_reg_offset, alu_opcode, alu_instr_mask,
    input  alu_valid, alu_vd, alu_index
  );

  modport slave (
    input  alu_run, alu_byte_i, alu_in_reg_offset, alu_opcode, alu_instr_mask,
    output alu_valid, alu_vd, alu_index
  );
endinterface

// File: rtl/rvv_elem_counter.sv
// Nested element / chunk counter; offset always returns to 0 at an element boundary.
module rvv_elem_counter #(
  parameter int BW = 10,
  parameter int OW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          en,
  input  logic [CW-1:0] chunks,
  input  logic [BW-1:0] nel,
  output logic [BW-1:0] byte_i,
  output logic [OW-1:0] offset,
  output logic          last
);

  logic elem_last;

  assign elem_last = (CW'(offset) == chunks - 1'b1);
  assign last      = elem_last && (byte_i == nel - 1'b1);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      byte_i <= '0;
      offset <= '0;
    end else if (en) begin
      if (elem_last) begin
        offset <= '0;
        byte_i <= byte_i + 1'b1;
      end else begin
        offset <= offset + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvv_alu_seq.sv
// Walks one vector operation through the lane-sliced ALU and scatters each
// lane result into the destination buffer at the ALU-reported bit index.
module rvv_alu_seq
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            kill,
  input  logic [5:0]      opcode,
  input  logic            instr_mask,
  input  logic [2:0]      vsew,
  input  logic [7:0]      vl,
  input  logic [VLEN-1:0] vd_old,
  rvv_alu_seq_if.master   alu,
  output logic [VLEN-1:0] vd_out,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int LW = 1 << LANE_WIDTH;

  seq_state_e      state, state_n;
  op_cfg_t         cfg;
  logic            err_q;
  logic [7:0]      chunks;
  logic [9:0]      nel;
  logic [15:0]     vbits;
  logic            chk_err;
  logic            run;
  logic            last;
  logic            in_range;
  logic [9:0]      byte_i;
  logic [3:0]      offset;
  int              ww;
  logic [LW-1:0]   lane_mask;
  logic [VLEN-1:0] wmask, wdata;
  logic            unused;

  assign chunks  = cfg.instr_mask ? 8'd1 : chunks_for(cfg.vsew, LANE_WIDTH);
  assign nel     = cfg.instr_mask ? 10'(VLEN / LW) : {2'b00, cfg.vl};
  assign vbits   = 16'(cfg.vl) << ({1'b0, cfg.vsew[1:0]} + 3'd3);
  assign chk_err = !alu.alu_valid || (cfg.vsew > SEW64) ||
                   (!cfg.instr_mask && (vbits > 16'(VLEN)));

  // Write width is the element width, capped at one lane.
  always_comb begin
    ww = 8 << cfg.vsew[1:0];
    if (ww > LW) ww = LW;
    lane_mask = '0;
    for (int i = 0; i < LW; i++) lane_mask[i] = (i < ww);
  end

  assign in_range = (int'(alu.alu_index) + ww) <= VLEN;
  assign wmask    = VLEN'(lane_mask) << alu.alu_index;
  assign wdata    = VLEN'(alu.alu_vd[LW-1:0]) << alu.alu_index;
  assign unused   = &{1'b0, alu.alu_vd[63:LW]};

  rvv_elem_counter #(.BW(10), .OW(4), .CW(8)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state != RUN),
    .en     (run),
    .chunks (chunks),
    .nel    (nel),
    .byte_i (byte_i),
    .offset (offset),
    .last   (last)
  );

  assign alu.alu_run           = run;
  assign alu.alu_byte_i        = byte_i;
  assign alu.alu_in_reg_offset = offset;
  assign alu.alu_opcode        = cfg.opcode;
  assign alu.alu_instr_mask    = cfg.instr_mask;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    run     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE:  if (start) state_n = CHECK;
      CHECK: begin
        busy    = 1'b1;
        state_n = (chk_err || nel == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        run  = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Abort wins over any completion in the same cycle.
    if (kill && state != IDLE) begin
      state_n = IDLE;
      run     = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cfg    <= '0;
      err_q  <= 1'b0;
      vd_out <= '0;
    end else begin
      if (state == IDLE && start) begin
        cfg    <= '{opcode: opcode, instr_mask: instr_mask, vsew: vsew, vl: vl};
        err_q  <= 1'b0;
        vd_out <= vd_old;
      end else if (run && in_range) begin
        vd_out <= (vd_out & ~wmask) | (wdata & wmask);
      end
      if (state == CHECK) err_q <= chk_err;
    end
  end

endmodule

// File: doc/rvv_alu_seq.md
Name: rvv_alu_seq

Overview:
- Sequencer for the lane-sliced vector ALU.
- On `start`, it walks every element of one vector operation in order (`byte_i`) and every lane-sized chunk within each element (`in_reg_offset`), pulses `run` to the ALU, and scatters each lane result into a VLEN-bit destination buffer at the ALU-reported bit index.
- When the walk is finished it presents the assembled vector with a one-cycle `done`.
- It sits between the vector decode/issue stage and the ALU instance.

Parameters:
- VLEN, 128, vector register length in bits.
- LANE_WIDTH, 3, log2 of the lane width in bits (LW = 1<<LANE_WIDTH = 8); must match the ALU instance.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- start  in  1  launch request, sampled in IDLE only
- kill  in  1  abort the current operation
- opcode  in  6  function code, forwarded to the ALU
- instr_mask  in  1  mask-instruction select, forwarded to the ALU
- vsew  in  3  element width code (0..3 gives 8..64 bits)
- vl  in  8  active element count
- vd_old  in  VLEN  prior destination contents; supplies tail/undisturbed bits
- alu_valid  in  1  ALU legality flag for opcode/instr_mask
- alu_vd  in  64  ALU lane result; low LW bits are used
- alu_index  in  10  ALU bit index of the current chunk
- alu_run  out  1  ALU enable
- alu_byte_i  out  10  element counter
- alu_in_reg_offset  out  4  chunk counter within the element
- vd_out  out  VLEN  destination buffer
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  illegal-operation flag, valid with done

Behaviour:
- Reset values: state IDLE; all outputs 0; vd_out 0; counters 0.

Derived quantities, latched at start:
- SEW = 8<<vsew.
- CHUNKS = (SEW > LW) ? SEW/LW : 1.
- WW = min(SEW, LW).
- Mask instructions (instr_mask=1) override these: NEL = VLEN/LW and CHUNKS = 1.
- Otherwise NEL = vl.

State machine (IDLE -> CHECK -> RUN -> DONE -> IDLE):
- IDLE: on start=1, latch opcode, instr_mask, vsew and vl; load vd_out <= vd_old; busy=1; go to CHECK. start in any other state is ignored.
- CHECK (1 cycle, alu_run=0): err if !alu_valid, vsew>3, or (non-mask and vl*SEW > VLEN).
  - err or NEL==0: go to DONE with err set accordingly.
  - otherwise go to RUN with counters at 0.
- RUN: alu_run=1 every cycle.
  - Each cycle, vd_out[alu_index +: WW] <= alu_vd[WW-1:0] is written at the clock edge.
  - Offset increments each cycle. When offset == CHUNKS-1, offset resets to 0 and byte_i increments.
  - After the chunk with byte_i == NEL-1 and offset == CHUNKS-1 is written, go to DONE.
- DONE: done=1 for exactly one cycle; err held for that cycle; busy=0; vd_out is held until the next start; go to IDLE.

Latency and sequencing rules:
- Latency from start to done is 2 + NEL*CHUNKS cycles.
- The offset sequence within each element must be strictly 0..CHUNKS-1 with no gaps. The ALU's carry and compare state relies on offset returning to 0 at every element boundary.
- Elements at or above vl keep their vd_old value (tail undisturbed).
- The alu_index bounds check is always in range when vl passed CHECK; an out-of-range write is ignored.

kill:
- In any non-IDLE state, go to IDLE next cycle.
- alu_run drops, busy=0, no done pulse, vd_out keeps its partial contents.
- kill has priority over completion in the same cycle.

Reset mid-operation: returns to IDLE with all reset values, regardless of state.

Decomposition:
- Shared package rvv_pkg holds:
  - opcode localparams for the ALU function set;
  - vsew encodings;
  - the state enum (IDLE, CHECK, RUN, DONE);
  - the function chunks_for(vsew, LANE_WIDTH).
- One natural sub-module, rvv_elem_counter: the nested byte_i/in_reg_offset counter with CHUNKS/NEL wrap, a last-chunk flag and a clear input.

Test Plan:
- vadd (000000), vsew=0, vl=16, LW=8, vs2=vs1=0x01 per byte -> alu_run high 16 cycles; offset stays 0; done at cycle 18; every vd_out byte = 0x02.
- vadd, vsew=2, vl=4, element 0 = 0x000000FF + 0x00000001 -> offset sequence 0,1,2,3 per element; byte_i 0..3; 16 RUN cycles; vd_out[31:0]=0x00000100.
- vsew=1, vl=3, vd_old all 0xAA -> 6 RUN cycles; vd_out bits [127:48] remain 0xAA...; done at cycle 8.
- opcode 6'b111111 (alu_valid=0) -> no alu_run; done and err asserted at cycle 2; vd_out == vd_old.
- kill on RUN cycle 5 of a vsew=3, vl=2 op -> busy low next cycle; no done; a start 1 cycle later is accepted normally.
- Mask instruction vmand (011001, instr_mask=1), vl=5 -> 16 RUN cycles regardless of vl; start asserted during RUN is ignored; exactly one done pulse.
